// File: rtl/registro_universal_n.sv
// -----------------------------------------------------------------------------
// registro_universal_n
//
// Parametrised universal register: hold, shift right, shift left and parallel
// load, with serial in/out at both ends and optional rotate. A burst engine
// runs NSHIFT shifts from a single START strobe, with a BUSY/DONE handshake.
//
// Parameters:
//   WIDTH  register width in bits (>= 2)
//   CNT_W  width of the burst shift count NSHIFT
//
// Ports:
//   CLK      clock; all state updates on the rising edge
//   RESET    synchronous active-high reset (aborts a burst, no DONE)
//   EN       enables continuous MODO operation while idle
//   MODO     00 hold, 01 shift right, 10 shift left, 11 parallel load
//   ROTAR    1: shifts rotate, 0: shifts fill from S_IN_R / S_IN_L
//   S_IN_R   fill bit entering at the MSB on a right shift
//   S_IN_L   fill bit entering at the LSB on a left shift
//   D        parallel load data
//   START    burst command strobe (only honoured in IDLE)
//   NSHIFT   number of shifts for a burst
//   Q        register contents
//   S_OUT_R  Q[0]
//   S_OUT_L  Q[WIDTH-1]
//   BUSY     burst in progress
//   DONE     one-cycle completion pulse
//   PARIDAD  (only with PARIDAD_EN) registered XOR of Q, 1 for odd ones
//
// Optional feature macro: PARIDAD_EN adds the PARIDAD output.
// -----------------------------------------------------------------------------
module registro_universal_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODO,
    input  logic             ROTAR,
    input  logic             S_IN_R,
    input  logic             S_IN_L,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] NSHIFT,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT_R,
    output logic             S_OUT_L,
    output logic             BUSY,
    output logic             DONE
`ifdef PARIDAD_EN
    ,
    output logic             PARIDAD
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_left_q, dir_left_d;   // latched burst direction
    logic             rot_q, rot_d;             // latched burst ROTAR

    // One shift step; serial inputs are always taken live.
    function automatic logic [WIDTH-1:0] do_shift(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             rot,
        input logic             sin_r,
        input logic             sin_l
    );
        logic fill;
        if (left) begin
            fill = rot ? v[WIDTH-1] : sin_l;
            return {v[WIDTH-2:0], fill};
        end else begin
            fill = rot ? v[0] : sin_r;
            return {fill, v[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        dir_left_d = dir_left_q;
        rot_d      = rot_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    // A burst command wins over continuous operation.
                    case (MODO)
                        2'b01, 2'b10: begin
                            if (NSHIFT != '0) begin
                                dir_left_d = MODO[1];
                                rot_d      = ROTAR;
                                cnt_d      = NSHIFT;
                                state_d    = ST_SHIFT;
                            end else begin
                                state_d = ST_FIN;
                            end
                        end
                        2'b11: begin
                            q_d     = D;
                            state_d = ST_FIN;
                        end
                        default: state_d = ST_FIN;
                    endcase
                end else if (EN) begin
                    case (MODO)
                        2'b01:   q_d = do_shift(q_q, 1'b0, ROTAR, S_IN_R, S_IN_L);
                        2'b10:   q_d = do_shift(q_q, 1'b1, ROTAR, S_IN_R, S_IN_L);
                        2'b11:   q_d = D;
                        default: q_d = q_q;
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d   = do_shift(q_q, dir_left_q, rot_q, S_IN_R, S_IN_L);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            rot_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            dir_left_q <= dir_left_d;
            rot_q      <= rot_d;
        end
    end

    assign Q       = q_q;
    assign S_OUT_R = q_q[0];
    assign S_OUT_L = q_q[WIDTH-1];
    assign BUSY    = (state_q == ST_SHIFT);
    assign DONE    = (state_q == ST_FIN);

`ifdef PARIDAD_EN
    logic paridad_q, paridad_d;

    // Parity of the value Q takes on this edge, so it tracks Q exactly.
    always_comb begin
        paridad_d = ^q_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            paridad_q <= 1'b0;
        end else begin
            paridad_q <= paridad_d;
        end
    end

    assign PARIDAD = paridad_q;
`endif

endmodule

// File: doc/registro_universal_n.md
Name: registro_universal_n

Overview:
Parametrised successor to the team's fixed 4-bit shift/load register. Provides WIDTH-bit hold, shift right, shift left and parallel load, with serial in/out at both ends and optional rotate. Adds a burst engine: one START command performs NSHIFT shifts autonomously, with BUSY/DONE handshake. Sits in the same register datapath, driven by a host controller.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 3, width of the burst shift count NSHIFT

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET  input  1  synchronous reset, active-high
EN  input  1  enables continuous (non-burst) operation in IDLE
MODO  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
ROTAR  input  1  1: shifts rotate; 0: shifts fill from serial inputs
S_IN_R  input  1  serial fill bit entering at MSB on shift right
S_IN_L  input  1  serial fill bit entering at LSB on shift left
D  input  WIDTH  parallel load data
START  input  1  burst command strobe
NSHIFT  input  CNT_W  number of shifts for a burst
Q  output  WIDTH  register contents
S_OUT_R  output  1  Q[0], combinational from Q
S_OUT_L  output  1  Q[WIDTH-1], combinational from Q
BUSY  output  1  burst in progress
DONE  output  1  one-cycle completion pulse

Behaviour:
- Reset (RESET=1 at edge): Q=0, BUSY=0, DONE=0, internal count=0, state IDLE. Overrides everything; aborts a burst mid-way without DONE.
- Shift right: Q <= {fill, Q[WIDTH-1:1]}, fill = ROTAR ? Q[0] : S_IN_R. Shift left: Q <= {Q[WIDTH-2:0], fill}, fill = ROTAR ? Q[WIDTH-1] : S_IN_L.
- States: IDLE, SHIFT, FIN.
- IDLE, START=0: if EN=1 apply MODO every edge; if EN=0 hold. BUSY=0, DONE=0.
- IDLE, START=1 (takes priority over EN), edge E0:
  - MODO 01/10 and NSHIFT>0: latch direction and ROTAR, count<=NSHIFT, go SHIFT; Q unchanged at E0.
  - MODO 01/10 and NSHIFT=0: go FIN, Q unchanged.
  - MODO 11: Q<=D at E0, go FIN.
  - MODO 00: Q unchanged, go FIN.
- SHIFT: BUSY=1. Each edge performs one shift with latched direction/ROTAR; S_IN_R/S_IN_L sampled live each edge. count decrements; edge with count=1 goes FIN. N shifts occupy edges E1..EN.
- FIN: BUSY=0, DONE=1 for exactly one cycle; next edge returns to IDLE; Q held. START in FIN ignored.
- START, MODO, EN, NSHIFT, D ignored while BUSY=1.
- Latency: burst of N>0 gives DONE high in the cycle after EN; N=0/load/hold give DONE in the cycle after E0.
- Max burst 2^CNT_W-1; shifts >= WIDTH without ROTAR fully replace Q with serial bits; with ROTAR, WIDTH shifts restore Q.

Optional Feature:
PARIDAD_EN: defined -> extra output PARIDAD (1 bit), registered, equals XOR of Q (1 when Q has odd number of ones), updated on the same edge as Q, reset to 0. Undefined -> port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, RESET=1 one edge during active burst -> Q=0000, BUSY=0, no DONE pulse, state IDLE.
- EN=1, MODO=11, D=1011 -> Q=1011 next edge; MODO=01, ROTAR=0, S_IN_R=0 -> 0101, S_OUT_R=1.
- Q=1011, START, MODO=10, ROTAR=1, NSHIFT=3 -> BUSY high 3 cycles, Q 0111, 1110, 1101, then DONE 1 cycle, Q=1101.
- Q=1001, START, MODO=01, ROTAR=0, NSHIFT=5, S_IN_R=1 constant -> final Q=1111, DONE after fifth shift.
- START, NSHIFT=0, MODO=01 -> Q unchanged, DONE next cycle, BUSY never high; START re-asserted while BUSY=1 -> ignored, count unaffected.
- PARIDAD_EN defined, load D=0111 -> PARIDAD=1; shift left with S_IN_L=1 -> Q=1111, PARIDAD=0.
